// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// Requester-side and TX-core-side signals of the UART TX arbiter, grouped as one bundle.
// master: requesters plus TX core model; slave: the arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 uart_tx_en;
    logic [7:0]           uart_tx_data;
    logic                 uart_tx_busy;

    modport master (
        output req_valid,
        output req_data,
        output req_last,
        output uart_tx_busy,
        input  req_ready,
        input  uart_tx_en,
        input  uart_tx_data
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        input  uart_tx_busy,
        output req_ready,
        output uart_tx_en,
        output uart_tx_data
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// =============================================================================
// uart_tx_arbiter: round-robin, packet-locked arbiter in front of one UART TX.
// Optional idle-timeout grant revocation: define UART_TX_ARB_TIMEOUT_EN.
// Revision: 1.0
// =============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_W = 10
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_tx_arbiter_if.slave    bus,
    output logic                grant_active,
    output logic [ID_W-1:0]     grant_id,
    output logic                timeout_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_GUARD  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [ID_W-1:0] r_grant_id;
    logic [ID_W-1:0] r_last_g;
    logic [ID_W-1:0] w_pick;
    logic [ID_W-1:0] w_idx;
    logic            w_found;
    logic            r_pkt_end;
    logic            w_accept;
    logic            w_timeout;
    logic            w_grant_valid;
    logic            w_grant_last;
    logic [7:0]      w_grant_data;

    assign w_grant_valid = bus.req_valid[r_grant_id];
    assign w_grant_last  = bus.req_last[r_grant_id];
    assign w_grant_data  = bus.req_data[{r_grant_id, 3'b000} +: 8];

    // Search starts one past the previous grantee so every requester gets a turn.
    always_comb begin
        w_pick  = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_last_g) + k) % NUM_REQ);
            if (!w_found && bus.req_valid[w_idx]) begin
                w_pick  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_grant_valid && !bus.uart_tx_busy) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_GUARD;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GUARD: begin
                w_state_nxt = r_pkt_end ? ST_IDLE : ST_LOCKED;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_grant_id <= '0;
            r_last_g   <= ID_W'(NUM_REQ - 1);
            r_pkt_end  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_found) begin
                r_grant_id <= w_pick;
            end
            if (w_accept) begin
                r_pkt_end <= w_grant_last;
            end
            if ((r_state == ST_GUARD && r_pkt_end) || w_timeout) begin
                r_last_g <= r_grant_id;
            end
        end
    end

    // Ready is withheld in GUARD to cover the TX core's one-cycle busy latency.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
        assign bus.req_ready[i] = (r_state == ST_LOCKED) && (r_grant_id == ID_W'(i))
                                  && !bus.uart_tx_busy;
    end

    assign bus.uart_tx_en   = w_accept;
    assign bus.uart_tx_data = w_accept ? w_grant_data : 8'h00;
    assign grant_active     = (r_state != ST_IDLE);
    assign grant_id         = r_grant_id;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] c_to_last = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    logic [TIMEOUT_W-1:0] r_to_cnt;
    logic                 r_timeout_pulse;
    logic                 w_stall;

    // The counter only advances while the grantee has nothing to offer and the line is free.
    assign w_stall   = (r_state == ST_LOCKED) && !w_grant_valid && !bus.uart_tx_busy;
    assign w_timeout = w_stall && (r_to_cnt == c_to_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_to_cnt        <= '0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_timeout_pulse <= w_timeout;
            if (r_state != ST_LOCKED || w_accept) begin
                r_to_cnt <= '0;
            end else if (w_stall) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign timeout_pulse = r_timeout_pulse;
`else
    assign w_timeout     = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// Directed bench for uart_tx_arbiter: reset, packet lock, round-robin, busy hold,
// idle timeout (or indefinite hold without UART_TX_ARB_TIMEOUT_EN) and reset mid-packet.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            grant_active;
    logic [ID_W-1:0] grant_id;
    logic            timeout_pulse;

    int n_checks = 0;
    int n_errors = 0;
    int en_count = 0;
    int to_count = 0;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

`ifdef UART_TX_ARB_TIMEOUT_EN
    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_W(4)) dut (
`else
    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
`endif
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .grant_active  (grant_active),
        .grant_id      (grant_id),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.uart_tx_en === 1'b1) en_count <= en_count + 1;
        if (timeout_pulse === 1'b1) to_count <= to_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input int d, input logic l);
        bus.req_valid[i]       = v;
        bus.req_data[8*i +: 8] = d[7:0];
        bus.req_last[i]        = l;
    endtask

    // Waits for the next start pulse, checks it, then returns at the following (GUARD) negedge.
    task automatic wait_tx(input string tag, input int d, input int id);
        int n = 0;
        #1;
        while (bus.uart_tx_en !== 1'b1 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_en"},    32'(bus.uart_tx_en),   32'd1);
        check({tag, "_data"},  32'(bus.uart_tx_data), 32'(d));
        check({tag, "_id"},    32'(grant_id),         32'(id));
        check({tag, "_ready"}, 32'(bus.req_ready),    32'd1 << id);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e0;
        int t0;
        int bad;

        // Reset with every requester asserting
        rst_n            = 1'b0;
        bus.req_valid    = '1;
        bus.req_data     = 32'h13121110;
        bus.req_last     = '1;
        bus.uart_tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready",  32'(bus.req_ready),    32'd0);
        check("rst_en",     32'(bus.uart_tx_en),   32'd0);
        check("rst_data",   32'(bus.uart_tx_data), 32'd0);
        check("rst_active", 32'(grant_active),     32'd0);
        check("rst_id",     32'(grant_id),         32'd0);
        check("rst_to",     32'(timeout_pulse),    32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_active", 32'(grant_active), 32'd1);
        wait_tx("first", 'h10, 0);
        bus.req_valid = '0;

        // Packet lock: requester 2 must wait for requester 1's whole packet
        e0 = en_count;
        set_req(1, 1'b1, 'h41, 1'b0);
        set_req(2, 1'b1, 'h55, 1'b1);
        wait_tx("lock_b0", 'h41, 1);
        set_req(1, 1'b1, 'h42, 1'b0);
        wait_tx("lock_b1", 'h42, 1);
        set_req(1, 1'b1, 'h43, 1'b1);
        wait_tx("lock_b2", 'h43, 1);
        set_req(1, 1'b0, 'h00, 1'b0);
        wait_tx("lock_b3", 'h55, 2);
        set_req(2, 1'b0, 'h00, 1'b0);
        check("lock_en_count", 32'(en_count - e0), 32'd4);

        // Round-robin over single-byte packets, starting from a fresh pointer
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 'hA0 + i, 1'b1);
        for (int p = 0; p < 6; p++) wait_tx($sformatf("rr%0d", p), 'hA0 + (p % 4), p % 4);
        bus.req_valid = '0;
        @(negedge clk);

        // Busy back-pressure
        bus.uart_tx_busy = 1'b1;
        set_req(0, 1'b1, 'h77, 1'b1);
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #1;
            if (bus.req_ready !== '0 || bus.uart_tx_en !== 1'b0) bad++;
        end
        check("busy_hold",   32'(bad),          32'd0);
        check("busy_active", 32'(grant_active), 32'd1);
        check("busy_id",     32'(grant_id),     32'd0);
        bus.uart_tx_busy = 1'b0;
        wait_tx("busy_rel", 'h77, 0);
        bus.req_valid = '0;
        @(negedge clk);

        // Stalled grantee: one non-last byte, then silence
        set_req(1, 1'b1, 'h31, 1'b0);
        set_req(3, 1'b1, 'h93, 1'b1);
        wait_tx("to_b0", 'h31, 1);
        set_req(1, 1'b0, 'h00, 1'b0);
        bus.uart_tx_busy = 1'b1;
        repeat (5) @(negedge clk);
        bus.uart_tx_busy = 1'b0;
        t0 = to_count;
        e0 = en_count;
`ifdef UART_TX_ARB_TIMEOUT_EN
        bad = 0;
        #1;
        while (timeout_pulse !== 1'b1 && bad < 100) begin
            @(negedge clk);
            #1;
            bad++;
        end
        check("to_delay",  32'(bad),          32'd15);
        check("to_active", 32'(grant_active), 32'd0);
        wait_tx("to_next", 'h93, 3);
        check("to_pulses", 32'(to_count - t0), 32'd1);
        bus.req_valid = '0;
`else
        repeat (200) @(negedge clk);
        #1;
        check("hold_active", 32'(grant_active),      32'd1);
        check("hold_id",     32'(grant_id),          32'd1);
        check("hold_no_to",  32'(to_count - t0),     32'd0);
        check("hold_no_en",  32'(en_count - e0),     32'd0);
        bus.req_valid = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif

        // Reset between bytes 2 and 3 of a 4-byte packet
        set_req(1, 1'b1, 'hC1, 1'b0);
        wait_tx("mid_b0", 'hC1, 1);
        set_req(1, 1'b1, 'hC2, 1'b0);
        wait_tx("mid_b1", 'hC2, 1);
        rst_n = 1'b0;
        set_req(1, 1'b1, 'hC3, 1'b0);
        set_req(0, 1'b1, 'hE0, 1'b1);
        @(negedge clk);
        #1;
        check("mid_active", 32'(grant_active),   32'd0);
        check("mid_ready",  32'(bus.req_ready),  32'd0);
        check("mid_en",     32'(bus.uart_tx_en), 32'd0);
        rst_n = 1'b1;
        wait_tx("post_rst", 'hE0, 0);
        bus.req_valid = '0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin, packet-locked arbiter that shares the single UART transmitter between several on-chip byte-stream requesters, e.g. a CPU console path and a DMA/debug path. It sits between the requesters and the UART TX core's `uart_tx_en` / `uart_tx_data` / `uart_tx_busy` interface. It grants one requester at a time and holds the grant until that requester's packet ends, so bytes from different requesters never interleave. An optional idle timeout breaks a stalled grant.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `ID_W`, 2: width of the grant index; must satisfy 2^ID_W ≥ NUM_REQ.
- `TIMEOUT_W`, 10: width of the idle-timeout counter; the timeout fires after 2^TIMEOUT_W − 1 cycles.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in NUM_REQ: per-requester byte valid.
- `req_data` in 8*NUM_REQ: per-requester byte; requester i uses bits [8i+7:8i].
- `req_last` in NUM_REQ: marks the requester's current byte as the last of its packet.
- `req_ready` out NUM_REQ: byte accepted when `req_valid[i] && req_ready[i]`.
- `uart_tx_en` out 1: one-cycle start pulse to the TX core.
- `uart_tx_data` out 8: byte to the TX core; valid while `uart_tx_en` is high.
- `uart_tx_busy` in 1: TX core busy. Rises the cycle after `uart_tx_en` and stays high until the frame completes.
- `grant_active` out 1: high while a requester holds the grant.
- `grant_id` out ID_W: index of the current or most recent grantee.
- `timeout_pulse` out 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- FSM states: IDLE, LOCKED, GUARD.
- Round-robin pointer `last_g`:
  - Resets to NUM_REQ−1, so requester 0 wins first.
  - Updated to the grantee on release.
- **IDLE**
  - If any `req_valid` is high, grant the first valid index searching `last_g+1, last_g+2, …` modulo NUM_REQ.
  - Latch that index into `grant_id` and go to LOCKED.
  - Otherwise remain in IDLE.
  - All `req_ready` are 0.
- **LOCKED** (grantee g)
  - `req_ready[g] = !uart_tx_busy`; all other `req_ready` bits are 0.
  - On accept, the following happen combinationally in the same cycle:
    - `uart_tx_en` = 1 and `uart_tx_data` = `req_data[g]`.
    - `req_last[g]` is registered as `pkt_end`.
    - The FSM goes to GUARD.
  - Non-grantees' `req_valid` is ignored; there is no preemption.
- **GUARD**
  - Lasts exactly one cycle; `req_ready` = 0, which covers the TX core's one-cycle busy latency.
  - If `pkt_end` is set: release the grant, set `last_g` = g, go to IDLE.
  - Otherwise go to LOCKED.
- **Fairness**: after a release, a continuously requesting requester waits at most NUM_REQ−1 packets.
- **Reset values**:
  - `req_ready` = 0, `uart_tx_en` = 0, `uart_tx_data` = 0.
  - `grant_active` = 0, `grant_id` = 0, `timeout_pulse` = 0.
  - State IDLE, timeout counter 0.
- **Reset mid-packet**: the grant is dropped immediately with no flush. A byte already handed to the TX core completes under the TX core's own reset rules.
- `uart_tx_data` outputs 0 whenever `uart_tx_en` is 0.

## Timing
- Grant latency: a requester asserting `req_valid` in cycle N while in IDLE is granted at the edge ending N. Its byte is accepted in cycle N+1 at the earliest, if `uart_tx_busy` = 0.
- `uart_tx_en` is high for exactly one cycle per accepted byte.
- At least 2 cycles separate consecutive `uart_tx_en` pulses (LOCKED → GUARD); in practice the spacing is one UART frame.
- Release to next grant:
  - Cycle GUARD: release.
  - Cycle IDLE: arbitration.
  - The next requester is LOCKED at the earliest 2 cycles after the final byte's accept.
- `req_valid` and `req_data` must stay stable while `req_valid` is high and not yet accepted.
- `grant_active` = 1 in LOCKED and GUARD, and 0 in IDLE.

## Configuration
- Macro `UART_TX_ARB_TIMEOUT_EN`.
- **Defined**: a TIMEOUT_W-bit counter runs in LOCKED.
  - It increments each cycle that `req_valid[g]` = 0 and the TX core is not busy.
  - It clears on accept and on entering LOCKED.
  - On reaching all-ones: pulse `timeout_pulse`, set `last_g` = g, go to IDLE.
  - The partial packet is abandoned.
  - Saturation and accept in the same cycle: accept wins, no timeout.
- **Undefined**:
  - No counter logic is present.
  - `timeout_pulse` is tied to 0.
  - A grantee may hold the grant indefinitely.

## Test plan
- **Reset**: hold `rst_n` = 0 for 3 cycles with all `req_valid` high → all outputs 0. After release, requester 0 is granted first (`grant_id` = 0).
- **Packet lock**:
  - Stimulus: requester 1 sends 3 bytes 0x41, 0x42, 0x43 (last on 0x43) while requester 2 holds `req_valid` with 0x55.
  - Required: `uart_tx_data` sequence 0x41, 0x42, 0x43, then 0x55. No interleave, one `uart_tx_en` per byte.
- **Round-robin**: all four requesters send continuous 1-byte packets → grant order 0, 1, 2, 3, 0, 1.
- **Busy back-pressure**:
  - Stimulus: hold `uart_tx_busy` = 1 for 100 cycles while granted.
  - Required: `req_ready[g]` = 0 and `uart_tx_en` = 0 throughout. The byte is accepted the first cycle busy = 0.
- **Timeout** (macro defined, TIMEOUT_W = 4):
  - Stimulus: the grantee sends one non-last byte, then drops `req_valid`.
  - Required: `timeout_pulse` fires 15 idle cycles after the TX core goes non-busy, and the next requester is granted.
  - With the macro undefined: the grant holds forever.
- **Reset mid-packet**: deassert `rst_n` between bytes 2 and 3 of a 4-byte packet → `grant_active` = 0 next cycle. After reset, arbitration restarts at requester 0.
